// File: rtl/alu_seq_exec.sv
// Sequential ALU: single-cycle logic/arith ops, bit-serial shifts, valid/ready on both sides.
// One operation in flight; the result is held in DONE until the consumer takes it.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | o_ready=1, waiting for i_valid; result register reads 0
// SHIFT | shifting result register one bit per edge, cnt_q bits left
// DONE  | o_valid=1, result held until i_ready
module alu_seq_exec #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [2:0]       i_alu_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_result,
    output logic             o_zero
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SLT = 3'b101;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] result_q;
    logic [WIDTH-1:0] alu_res;
    logic [4:0]       cnt_q;
    logic             shift_left_q;
    logic             is_shift;
    logic [4:0]       shamt;

    assign is_shift = (i_alu_op[2:1] == 2'b11);
    assign shamt    = i_b[4:0];

    always_comb begin
        alu_res = '0;
        case (i_alu_op)
            OP_ADD:  alu_res = i_a + i_b;
            OP_SUB:  alu_res = i_a - i_b;
            OP_AND:  alu_res = i_a & i_b;
            OP_OR:   alu_res = i_a | i_b;
            OP_XOR:  alu_res = i_a ^ i_b;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
            default: alu_res = i_a;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (i_valid) begin
                    if (is_shift && (shamt != 5'd0)) begin
                        state_d = ST_SHIFT;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_SHIFT: begin
                // cnt_q of 0 cannot occur here; treated as last step so the FSM never sticks
                if (cnt_q <= 5'd1) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (i_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            result_q     <= '0;
            cnt_q        <= '0;
            shift_left_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (i_valid) begin
                        if (is_shift) begin
                            result_q     <= i_a;
                            cnt_q        <= shamt;
                            shift_left_q <= ~i_alu_op[0];
                        end else begin
                            result_q <= alu_res;
                            cnt_q    <= '0;
                        end
                    end
                end
                ST_SHIFT: begin
                    if (shift_left_q) begin
                        result_q <= {result_q[WIDTH-2:0], 1'b0};
                    end else begin
                        result_q <= {1'b0, result_q[WIDTH-1:1]};
                    end
                    cnt_q <= cnt_q - 5'd1;
                end
                ST_DONE: begin
                    // Clearing on hand-off makes IDLE look the same as just after reset
                    if (i_ready) begin
                        result_q <= '0;
                    end
                end
                default: begin
                    result_q <= '0;
                    cnt_q    <= '0;
                end
            endcase
        end
    end

    assign o_ready  = (state_q == ST_IDLE);
    assign o_valid  = (state_q == ST_DONE);
    assign o_result = result_q;
    assign o_zero   = (result_q == '0);

endmodule

// File: tb/tb_alu_seq_exec.sv
// Directed bench for alu_seq_exec: hand-computed results, latencies, busy and reset cases.
module tb_alu_seq_exec;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_valid;
    logic        o_ready;
    logic [2:0]  i_alu_op;
    logic [31:0] i_a;
    logic [31:0] i_b;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_result;
    logic        o_zero;

    int n_checks = 0;
    int n_fail   = 0;

    alu_seq_exec #(.WIDTH(32)) dut (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_alu_op (i_alu_op),
        .i_a      (i_a),
        .i_b      (i_b),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_result (o_result),
        .o_zero   (o_zero)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    // Accept one op, scramble the inputs, wait for o_valid, hold for `hold` cycles, then hand off.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_lat,
                          input int hold);
        int lat;
        check({tag, "_ready_before"}, {31'd0, o_ready}, 32'd1);
        i_alu_op = op;
        i_a      = a;
        i_b      = b;
        i_valid  = 1'b1;
        step();
        i_valid  = 1'b0;
        i_a      = 32'hDEAD_BEEF;
        i_b      = 32'h0000_001F;
        i_alu_op = op ^ 3'b011;
        lat = 0;
        while (!o_valid && lat < 40) begin
            if (o_ready) check({tag, "_busy_ready"}, {31'd0, o_ready}, 32'd0);
            step();
            lat++;
        end
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_result"}, o_result, exp);
        check({tag, "_zero"}, {31'd0, o_zero}, {31'd0, (exp == 32'd0)});
        for (int h = 0; h < hold; h++) begin
            step();
            check({tag, "_hold_valid"}, {31'd0, o_valid}, 32'd1);
            check({tag, "_hold_result"}, o_result, exp);
        end
        i_ready = 1'b1;
        step();
        i_ready = 1'b0;
        check({tag, "_valid_after"}, {31'd0, o_valid}, 32'd0);
        check({tag, "_ready_after"}, {31'd0, o_ready}, 32'd1);
    endtask

    initial begin
        int lat;
        int seen_valid;

        i_rst_n  = 1'b0;
        i_valid  = 1'b0;
        i_ready  = 1'b0;
        i_alu_op = 3'b000;
        i_a      = 32'd0;
        i_b      = 32'd0;
        step();
        step();
        i_rst_n = 1'b1;
        check("rst_ready",  {31'd0, o_ready}, 32'd1);
        check("rst_valid",  {31'd0, o_valid}, 32'd0);
        check("rst_result", o_result, 32'd0);
        check("rst_zero",   {31'd0, o_zero}, 32'd1);

        run_op("add",      3'b000, 32'd5,          32'd7,          32'd12,         0, 3);
        run_op("sub_zero", 3'b001, 32'h0000_1234,  32'h0000_1234,  32'd0,          0, 0);
        run_op("slt_neg",  3'b101, 32'hFFFF_FFFF,  32'd1,          32'd1,          0, 0);
        run_op("slt_pos",  3'b101, 32'd1,          32'hFFFF_FFFF,  32'd0,          0, 0);
        run_op("and",      3'b010, 32'hF0F0_FF00,  32'h0FF0_F0F0,  32'h00F0_F000,  0, 0);
        run_op("or",       3'b011, 32'hF0F0_FF00,  32'h0FF0_F0F0,  32'hFFF0_FFF0,  0, 0);
        run_op("xor",      3'b100, 32'hF0F0_FF00,  32'h0FF0_F0F0,  32'hFF00_0FF0,  0, 1);
        run_op("add_wrap", 3'b000, 32'hFFFF_FFFF,  32'd2,          32'd1,          0, 0);
        run_op("sub_wrap", 3'b001, 32'd0,          32'd1,          32'hFFFF_FFFF,  0, 0);
        run_op("sll4",     3'b110, 32'd1,          32'd4,          32'h0000_0010,  4, 1);
        run_op("srl31",    3'b111, 32'h8000_0000,  32'd31,         32'd1,         31, 0);
        run_op("srl0",     3'b111, 32'hA5A5_A5A5,  32'h0000_0020,  32'hA5A5_A5A5,  0, 0);
        run_op("sll1_msb", 3'b110, 32'h8000_0001,  32'd1,          32'd2,          1, 0);
        run_op("srl1",     3'b111, 32'h8000_0001,  32'd1,          32'h4000_0000,  1, 0);

        // Busy: i_valid and i_ready stay high with changing operands through the shift
        i_alu_op = 3'b110;
        i_a      = 32'd3;
        i_b      = 32'd5;
        i_valid  = 1'b1;
        i_ready  = 1'b1;
        step();
        lat = 0;
        while (!o_valid && lat < 40) begin
            i_alu_op = 3'($urandom_range(0, 7));
            i_a      = $urandom;
            i_b      = $urandom;
            step();
            lat++;
        end
        check("busy_latency", lat, 5);
        check("busy_result", o_result, 32'h0000_0060);
        i_valid = 1'b0;
        step();
        i_ready = 1'b0;
        check("busy_valid_after", {31'd0, o_valid}, 32'd0);
        check("busy_ready_after", {31'd0, o_ready}, 32'd1);

        // Reset at shift cycle 2 of a 10-bit shift
        i_alu_op = 3'b110;
        i_a      = 32'd1;
        i_b      = 32'd10;
        i_valid  = 1'b1;
        step();
        i_valid  = 1'b0;
        step();
        i_rst_n = 1'b0;
        step();
        i_rst_n = 1'b1;
        check("midrst_ready",  {31'd0, o_ready}, 32'd1);
        check("midrst_valid",  {31'd0, o_valid}, 32'd0);
        check("midrst_result", o_result, 32'd0);
        check("midrst_zero",   {31'd0, o_zero}, 32'd1);
        seen_valid = 0;
        for (int k = 0; k < 14; k++) begin
            step();
            if (o_valid) seen_valid++;
        end
        check("midrst_no_valid", seen_valid, 0);

        // Reset while a result waits in DONE
        i_alu_op = 3'b000;
        i_a      = 32'd9;
        i_b      = 32'd1;
        i_valid  = 1'b1;
        step();
        i_valid = 1'b0;
        check("donerst_valid_pre", {31'd0, o_valid}, 32'd1);
        i_rst_n = 1'b0;
        step();
        i_rst_n = 1'b1;
        check("donerst_valid",  {31'd0, o_valid}, 32'd0);
        check("donerst_result", o_result, 32'd0);
        step();
        check("donerst_ready",  {31'd0, o_ready}, 32'd1);

        run_op("post_rst_add", 3'b000, 32'd100, 32'd23, 32'd123, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_seq_exec.md
ALU_SEQ_EXEC -- requirements
Module: alu_seq_exec

Interface
REQ-001 The module SHALL have the port i_clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 The module SHALL have the port i_rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-003 The module SHALL have the port i_valid, input, 1 bit: the request carries a valid operation.
REQ-004 The module SHALL have the port o_ready, output, 1 bit: the unit can accept a request this cycle.
REQ-005 The module SHALL have the port i_alu_op, input, 3 bits: operation code, as produced by ALU_Control.
REQ-006 The module SHALL have the port i_a, input, 32 bits: operand A (for shifts, the value to shift).
REQ-007 The module SHALL have the port i_b, input, 32 bits: operand B (for shifts, the shift amount in i_b[4:0]).
REQ-008 The module SHALL have the port o_valid, output, 1 bit: o_result and o_zero hold a completed result.
REQ-009 The module SHALL have the port i_ready, input, 1 bit: the consumer takes the result this cycle.
REQ-010 The module SHALL have the port o_result, output, 32 bits: the registered result.
REQ-011 The module SHALL have the port o_zero, output, 1 bit: asserted when o_result == 0.
REQ-012 The module SHALL have the parameter WIDTH, default 32, giving the width of the datapath.

Function
REQ-013 The operation codes SHALL be:
- 000 ADD
- 001 SUB
- 010 AND
- 011 OR
- 100 XOR
- 101 SLT (signed, result 0 or 1)
- 110 SLL
- 111 SRL (logical)
REQ-014 ADD and SUB SHALL wrap modulo 2^WIDTH; no carry or overflow output.
REQ-015 The unit SHALL have three states: IDLE, SHIFT and DONE.
REQ-016 o_ready SHALL be 1 only in IDLE; a request is accepted on a rising edge where the state is IDLE and i_valid is 1.
REQ-017 A non-shift op accepted at edge N SHALL load its result into the result register and enter DONE at edge N, so o_valid is 1 in the cycle after edge N (latency 1).
REQ-018 A shift op with shamt = i_b[4:0] = 0 SHALL load i_a unchanged and enter DONE at the accept edge (latency 1).
REQ-019 A shift op with shamt > 0 SHALL load i_a and enter SHIFT with counter = shamt.
- Each SHIFT edge shifts the register by exactly 1 bit (left for SLL, right with zero fill for SRL) and decrements the counter.
- The edge on which the counter goes from 1 to 0 also transitions to DONE.
- o_valid therefore rises shamt cycles after acceptance (latency = shamt, at most 31).
REQ-020 i_alu_op, i_a and i_b SHALL be captured at acceptance; changes to them after acceptance SHALL have no effect on the operation in progress.
REQ-021 In DONE, o_valid SHALL be 1 and o_result/o_zero SHALL be held stable until an edge where i_ready is 1; that edge returns the unit to IDLE with o_valid 0.
REQ-022 There SHALL be no back-to-back acceptance: the earliest next accept is the edge after the DONE to IDLE edge.
REQ-023 i_valid asserted in SHIFT or DONE SHALL be ignored (no capture, no error).
REQ-024 i_ready asserted in IDLE or SHIFT SHALL be ignored.
REQ-025 o_zero SHALL be derived from the registered result and SHALL be valid whenever o_valid is 1.

Reset
REQ-026 While i_rst_n is 0 at a rising edge, the state SHALL become IDLE and the next cycle SHALL show o_ready=1, o_valid=0, o_result=0, o_zero=1, shift counter=0.
REQ-027 Reset SHALL take priority over all handshakes; a reset during SHIFT or DONE SHALL abort the operation and discard the result, with no o_valid pulse afterward.
REQ-028 No output SHALL change asynchronously with respect to i_rst_n.

Verification
REQ-029 ADD: i_alu_op=000, i_a=5, i_b=7, i_valid=1 for one cycle -> next cycle o_valid=1, o_result=12, o_zero=0; the values are held while i_ready=0 for 3 cycles and cleared after i_ready=1.
REQ-030 SUB/zero: i_alu_op=001, i_a=i_b=0x1234 -> o_result=0, o_zero=1; SLT with i_a=0xFFFFFFFF, i_b=1 -> o_result=1.
REQ-031 SLL: i_alu_op=110, i_a=1, i_b=4 -> o_ready=0 for 4 cycles, then o_valid=1 with o_result=0x10; SRL with i_a=0x80000000, i_b=31 -> o_result=1 after 31 cycles.
REQ-032 Shift amount 0: i_alu_op=111, i_a=0xA5A5A5A5, i_b=0x20 (shamt=0) -> latency 1, o_result=0xA5A5A5A5.
REQ-033 Busy and mid-reset: i_valid held high with changing operands during SHIFT -> the first request's result only; i_rst_n=0 at shift cycle 2 of a 10-bit shift -> IDLE next cycle, o_valid stays 0.
